// File: rtl/alu_pkg.sv
// Definitions shared by the multiply/divide ALU and its issue controller.
package alu_pkg;

  // Flag bit positions. Bits at and above NUM_FLAGS are passed through.
  localparam int MUL_OVF   = 0;
  localparam int DIV_REM   = 1;
  localparam int DIV_ZERO  = 2;
  localparam int DIV_OVF   = 3;
  localparam int NUM_FLAGS = 4;

  // Opcodes. Any other value is a no-op.
  localparam int OP_DIV = 0;
  localparam int OP_MUL = 1;

  // Issue controller sequencing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channels between a requester and the ALU issue controller.
interface alu_issue_ctrl_if #(
  parameter int L = 16,
  parameter int P = 0
) ();
  logic         req_valid;
  logic         req_ready;
  logic [P:0]   req_op;
  logic [L-1:0] req_a;
  logic [L-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [L-1:0] rsp_r;
  logic [L-1:0] rsp_flags;

  // Requester side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_flags
  );

  // Issue controller side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential initiator for the combinational multiply/divide ALU: registers
// one operation, holds the ALU inputs for a settle window, captures the
// result and owns the sticky flags register fed back into the ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int L      = 16,
  parameter int P      = 0,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  input  logic             flags_clr,
  output logic [P:0]       alu_op,
  output logic [L-1:0]     alu_a,
  output logic [L-1:0]     alu_b,
  output logic [L-1:0]     alu_flags_in,
  input  logic [L-1:0]     alu_r,
  input  logic [L-1:0]     alu_flags_out,
  output logic [L-1:0]     flags
);

  // Counter loads SETTLE-1 on accept; capture happens on the edge it is 0.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  issue_state_e state_q, state_d;
  logic [P:0]   op_q, op_d;
  logic [L-1:0] a_q, a_d;
  logic [L-1:0] b_q, b_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [L-1:0] rsp_r_q, rsp_r_d;
  logic [L-1:0] rsp_flags_q, rsp_flags_d;
  logic [L-1:0] flags_q, flags_d;

  // Handshake outputs come straight from the state.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_flags = rsp_flags_q;

  // ALU inputs only ever come from registers so they are stable during WAIT.
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_flags_in = flags_q;
  assign flags        = flags_q;

  // Next-state and datapath selection.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rsp_r_d     = rsp_r_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;

    // A clear is honoured in any state; the capture below overrides it.
    if (flags_clr) flags_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_r_d     = alu_r;
          rsp_flags_d = alu_flags_out;
          flags_d     = alu_flags_out;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rsp_r_q     <= rsp_r_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

endmodule
